// File: rtl/prefetch_unit.sv
// Sequential Avalon-MM instruction prefetcher feeding a {data, pc} queue; reads are throttled so a response always has a slot.
// Redirect flushes the queue and marks every in-flight read, including a stalled one, for discard.
module prefetch_unit #(
  parameter int          XLEN            = 32,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] address,
  output logic            read,
  output logic [3:0]      byteenable,
  input  logic            waitrequest,
  input  logic            readdatavalid,
  input  logic [XLEN-1:0] agent_to_host,
  output logic            ins_valid,
  output logic [XLEN-1:0] ins_data,
  output logic [XLEN-1:0] ins_pc,
  input  logic            ins_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUTSTANDING);

  logic            r_read;
  logic [XLEN-1:0] r_address;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_occ;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   r_disc;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [XLEN-1:0] r_dat [DEPTH];
  logic [XLEN-1:0] r_pc  [DEPTH];

  logic            w_accept;
  logic            w_stalled;
  logic            w_push;
  logic            w_pop;
  logic            w_room;
  logic            w_load;
  logic [CW-1:0]   w_out_nxt;
  logic [CW-1:0]   w_occ_nxt;
  logic [CW-1:0]   w_disc_nxt;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_base;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign read       = r_read;
  assign address    = r_address;
  assign byteenable = 4'b1111;
  assign ins_valid  = (r_occ != '0) & ~redirect & ~rst;
  assign ins_data   = r_dat[r_head];
  assign ins_pc     = r_pc[r_head];

  always_comb begin
    w_accept   = r_read & ~waitrequest;
    w_stalled  = r_read & waitrequest;
    w_redir_pc = redirect_pc & ~XLEN'(3);
    w_push     = readdatavalid & ~redirect & (r_disc == '0);
    w_pop      = ins_valid & ins_ready;
    w_out_nxt  = r_out + CW'(w_accept) - CW'(readdatavalid);
    w_occ_nxt  = redirect ? '0 : r_occ + CW'(w_push) - CW'(w_pop);
    // A request stalled at redirect will still complete, so it joins the discard count.
    if (redirect)
      w_disc_nxt = w_out_nxt + CW'(w_stalled);
    else if (readdatavalid && (r_disc != '0))
      w_disc_nxt = r_disc - CW'(1);
    else
      w_disc_nxt = r_disc;
    w_room = (({1'b0, w_occ_nxt} + {1'b0, w_out_nxt}) < DEPTH_W) && (w_out_nxt < MAX_W);
    w_load = (~r_read | w_accept) & w_room;
    w_base = redirect ? w_redir_pc : r_fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read     <= 1'b0;
      r_address  <= '0;
      r_fetch_pc <= XLEN'(RESET_PC);
      r_resp_pc  <= XLEN'(RESET_PC);
      r_occ      <= '0;
      r_out      <= '0;
      r_disc     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      if (~r_read | w_accept)
        r_read <= w_room;
      if (w_load)
        r_address <= w_base;
      r_fetch_pc <= w_load ? w_base + XLEN'(4) : w_base;
      r_occ      <= w_occ_nxt;
      r_out      <= w_out_nxt;
      r_disc     <= w_disc_nxt;
      // Responses return in order, so the next kept one always belongs to r_resp_pc.
      if (redirect) begin
        r_head    <= '0;
        r_tail    <= '0;
        r_resp_pc <= w_redir_pc;
      end else begin
        if (w_push) begin
          r_tail    <= ptr_inc(r_tail);
          r_resp_pc <= r_resp_pc + XLEN'(4);
        end
        if (w_pop)
          r_head <= ptr_inc(r_head);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dat[r_tail] <= agent_to_host;
      r_pc[r_tail]  <= r_resp_pc;
    end
  end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning instruction/address width; only 32 is supported.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries; legal range 2..16.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, meaning maximum accepted-but-unanswered bus reads; legal range 1..DEPTH.
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port address, output, XLEN, Avalon-MM instruction read address.
REQ-008 SHALL have port read, output, 1, Avalon-MM read request.
REQ-009 SHALL have port byteenable, output, 4, constant 4'b1111.
REQ-010 SHALL have port waitrequest, input, 1, agent not accepting the request this cycle.
REQ-011 SHALL have port readdatavalid, input, 1, response data valid this cycle.
REQ-012 SHALL have port agent_to_host, input, XLEN, response data.
REQ-013 SHALL have port ins_valid, output, 1, queue head holds a valid instruction.
REQ-014 SHALL have port ins_data, output, XLEN, head instruction word.
REQ-015 SHALL have port ins_pc, output, XLEN, address the head word was fetched from.
REQ-016 SHALL have port ins_ready, input, 1, consumer takes head when ins_valid is also high.
REQ-017 SHALL have port redirect, input, 1, discard queue and in-flight reads, restart fetch.
REQ-018 SHALL have port redirect_pc, input, XLEN, new fetch address; bits [1:0] are ignored and treated as zero.

Function
REQ-019 SHALL accept a bus request only on a cycle with read=1 and waitrequest=0; fetch_pc then advances by 4, wrapping 32'hFFFF_FFFC to 0.
REQ-020 SHALL hold read and address stable while read=1 and waitrequest=1, including across a redirect.
REQ-021 SHALL assert read only when occupancy + outstanding < DEPTH and outstanding < MAX_OUTSTANDING, so a response can never find the queue full.
REQ-022 SHALL keep a FIFO of {data, pc}; each non-discarded response is pushed in arrival order, and its pc is the address of the matching request in issue order.
REQ-023 SHALL pop the head on ins_valid && ins_ready; a push and a pop in the same cycle leave occupancy unchanged.
REQ-024 SHALL provide ins_valid = (occupancy != 0) && !redirect; ins_data and ins_pc SHALL be the head entry and are don't-care when ins_valid=0.
REQ-025 SHALL treat a redirect as follows: occupancy is cleared, any pop that cycle is void, fetch_pc <= {redirect_pc[31:2], 2'b00}, and every read outstanding after that cycle (including one accepted that same cycle) is marked for discard.
REQ-026 SHALL drop, without pushing, a response that arrives in the redirect cycle itself.
REQ-027 SHALL decrement a discard counter for each response that arrives while it is nonzero and push nothing; new requests MAY issue while discards are pending, subject to REQ-021 with discards counted as outstanding.
REQ-028 SHALL, when a request is stalled by waitrequest at a redirect, let that request complete at the old address and count it as discarded; the first new-address request follows it.
REQ-029 SHALL, on back-to-back redirects, use the last redirect_pc; discards accumulate correctly.
REQ-030 SHALL issue the first request no earlier than the first cycle after rst deasserts; ins_valid is first possible 1 cycle after the first readdatavalid.
REQ-031 SHALL size its counters as $clog2(DEPTH+1) bits with no overflow or underflow reachable under legal Avalon behaviour.

Reset
REQ-032 SHALL, while rst=1, set read=0, address=0, ins_valid=0, occupancy=0, outstanding=0, discard=0, and fetch_pc=RESET_PC.
REQ-033 SHALL treat a reset mid-transaction as abandoning it; any readdatavalid during or after reset for a pre-reset request is the agent's responsibility and is not tracked.

Verification
REQ-034 SHALL be verified with this scenario: reset, agent with 0 wait states and 1-cycle latency, ins_ready=1 -> ins_pc sequence 0,4,8,C… with ins_data matching memory and no gaps after fill.
REQ-035 SHALL be verified with this scenario: ins_ready=0 and DEPTH=4 -> exactly 4 reads accepted, read then held 0, ins_pc=0; after one pop a single new read at 0x10.
REQ-036 SHALL be verified with this scenario: 2 reads outstanding (0x8, 0xC) and redirect to 0x103 -> both responses dropped, next ins_pc=0x100, then 0x104.
REQ-037 SHALL be verified with this scenario: waitrequest held high on a request at 0x20 and redirect to 0x400 -> address stays 0x20 until accepted, its data is dropped, and the next request is 0x400.
REQ-038 SHALL be verified with this scenario: redirect, readdatavalid and ins_ready all high in one cycle -> no push, no pop, ins_valid=0 that cycle, and the occupancy counter reads 0.
REQ-039 SHALL be verified with this scenario: redirect to 0xFFFF_FFFC -> fetch sequence 0xFFFF_FFFC then 0x0000_0000.
